// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants, divider state encoding and negation helper
package alu_pkg;
  localparam int WIDTH = 32;
  localparam logic [5:0] OP_DIV = 6'h1a;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    DZ   = 3'd4
  } state_t;
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction
endpackage

// File: rtl/alu_nr_divider_cla.sv
// CLA_32bit_adder: 32-bit carry-lookahead adder (A, B, Cin -> S, C_out; G_prime/P_prime group terms)
module CLA_32bit_adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        C_out,
  output logic        G_prime,
  output logic        P_prime
);
  logic [31:0] g, p, c;
  logic [7:0] gg, gp;
  logic [8:0] gc;
  assign g = A & B;
  assign p = A ^ B;
  assign gc[0] = Cin;
  for (genvar i = 0; i < 8; i++) begin : blk
    localparam int B0 = 4 * i;
    assign c[B0]   = gc[i];
    assign c[B0+1] = g[B0] | (p[B0] & gc[i]);
    assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & gc[i]);
    assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                   | (p[B0+2] & p[B0+1] & p[B0] & gc[i]);
    assign gg[i] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                 | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
    assign gp[i] = &p[B0+3:B0];
    assign gc[i+1] = gg[i] | (gp[i] & gc[i]);
  end
  assign S = p ^ c;
  assign C_out = gc[8];
  assign P_prime = &gp;
  always_comb begin
    G_prime = 1'b0;
    for (int i = 0; i < 8; i++) G_prime = gg[i] | (gp[i] & G_prime);
  end
endmodule

// File: rtl/alu_nr_divider.sv
// alu_nr_divider: sequential signed non-restoring divider (clk, clear, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero)
module alu_nr_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(ITERS);
  state_t state, state_nx;
  logic [WIDTH:0] a, new_a;
  logic [WIDTH-1:0] q, m, add_a, add_b, sum;
  logic [CW-1:0] count;
  logic sign_q, sign_r, calc, sub, c_out;
  logic [1:0] cla_unused;
  always_ff @(posedge clk)
    if (clear) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (divisor == '0 ? DZ : CALC) : IDLE;
      CALC:    state_nx = count == CW'(ITERS - 1) ? FIX : CALC;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      DZ:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // One shared adder: in CALC it adds/subtracts M to the shifted A; in FIX it restores A + M.
  assign calc  = state == CALC;
  assign sub   = calc & ~a[WIDTH];
  assign add_a = calc ? {a[WIDTH-2:0], q[WIDTH-1]} : a[WIDTH-1:0];
  assign add_b = sub ? ~m : m;
  // Sign bit of the 33-bit result: shifted A sign ^ extended B sign (1 when subtracting) ^ carry.
  assign new_a = {(calc ? a[WIDTH-1] : a[WIDTH]) ^ sub ^ c_out, sum};
  CLA_32bit_adder u_cla (
    .A      (add_a),
    .B      (add_b),
    .Cin    (sub),
    .S      (sum),
    .C_out  (c_out),
    .G_prime(cla_unused[0]),
    .P_prime(cla_unused[1])
  );
  always_ff @(posedge clk) begin
    if (clear) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // On a zero divisor Q carries the raw dividend through to the remainder.
          q           <= divisor == '0 ? dividend : abs_val(dividend);
          m           <= abs_val(divisor);
          sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sign_r      <= dividend[WIDTH-1];
          a           <= '0;
          count       <= '0;
          busy        <= 1'b1;
          div_by_zero <= 1'b0;
        end
        CALC: begin
          a     <= new_a;
          q     <= {q[WIDTH-2:0], ~new_a[WIDTH]};
          count <= count + CW'(1);
        end
        FIX: if (a[WIDTH]) a <= new_a;
        DONE: begin
          quotient  <= sign_q ? neg(q) : q;
          remainder <= sign_r ? neg(a[WIDTH-1:0]) : a[WIDTH-1:0];
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        DZ: begin
          quotient    <= '1;
          remainder   <= q;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_nr_divider.sv
// tb_alu_nr_divider: table-driven scoreboard bench for alu_nr_divider
module tb_alu_nr_divider;
  logic clk = 1'b0;
  logic clear, start, busy, done, div_by_zero;
  logic [31:0] dividend, divisor, quotient, remainder;
  typedef struct {
    logic [31:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int tests = 0;
  int fails = 0;
  alu_nr_divider dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic launch(input vec_t v, input bit push);
    @(negedge clk);
    dividend = v.dd;
    divisor  = v.dv;
    start    = 1'b1;
    if (push) sb.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("dz_cleared_on_start", 32'(div_by_zero), 32'd0);
  endtask
  task automatic finish_op(input string name, input int poke);
    int n;
    int bc;
    vec_t e;
    n  = 0;
    bc = 1;
    while (n < 100) begin
      @(negedge clk);
      if (n == poke) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (busy) bc++;
    end
    start = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
      return;
    end
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_scoreboard: got done expected no pending result", name);
      return;
    end
    e = sb.pop_front();
    chk({name, "_quotient"}, quotient, e.q);
    chk({name, "_remainder"}, remainder, e.r);
    chk({name, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
    chk({name, "_latency"}, 32'(n), 32'(e.lat));
    chk({name, "_busy_cycles"}, 32'(bc), 32'(e.lat));
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({name, "_quotient_hold"}, quotient, e.q);
  endtask
  function automatic vec_t mk(input logic [31:0] dd, input logic [31:0] dv,
                              input logic [31:0] q, input logic [31:0] r, input logic dz);
    vec_t v;
    v.dd  = dd;
    v.dv  = dv;
    v.q   = q;
    v.r   = r;
    v.dz  = dz;
    v.lat = dz ? 1 : 34;
    return v;
  endfunction
  initial begin
    vec_t v;
    int cnt;
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    vecs.push_back(mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0));
    vecs.push_back(mk(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0));
    vecs.push_back(mk(32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1));
    vecs.push_back(mk(32'd7, 32'd100, 32'd0, 32'd7, 1'b0));
    vecs.push_back(mk(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1));
    vecs.push_back(mk(32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0));
    vecs.push_back(mk(32'd0, 32'd5, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      logic [31:0] dd, dv;
      dd = $urandom;
      dv = $urandom >> $urandom_range(0, 28);
      if (dv == 32'd0) dv = 32'd3;
      if (dd == 32'h80000000 && dv == 32'hFFFFFFFF) dv = 32'd9;
      vecs.push_back(mk(dd, dv, 32'($signed(dd) / $signed(dv)), 32'($signed(dd) % $signed(dv)), 1'b0));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i], 1'b1);
      finish_op($sformatf("vec%0d", i), -1);
    end
    launch(mk(32'd7, 32'd100, 32'd0, 32'd7, 1'b0), 1'b1);
    finish_op("busy_start_ignored", 5);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_no_restart", 32'(busy), 32'd0);
    chk("busy_start_result_kept", remainder, 32'd7);
    launch(mk(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0), 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    v = mk(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    launch(v, 1'b1);
    finish_op("after_abort", -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
